game_board_ram: RTL and testbench
=================================

Name: game_board_ram

Overview:
- Wishbone responder (slave) that stores the game board cell array.
- The mine planter and the game logic write and read cells through game_board_wb, acting as bus master.
- A second, read-only port serves the display/renderer.
- An internal clear sequencer zeroes the whole array after reset and on request, and holds the bus off while it runs.

Parameters:
- DEPTH, 1024: number of cells; must be ≤ 2**ADDR_W.
- ADDR_W, 10: cell address width, on both the bus and the display port.
- DATA_W, 8: cell width. Bit 7 = mine, bit 6 = revealed, bit 5 = flagged, bits 3:0 = neighbour count.

Ports:
- clk  input  1: system clock; the only clock.
- rst  input  1: synchronous, active-high reset.
- game_board_wb  wishbone_if.slave  -: uses cyc_o, stb_o, we_o, adr_o[ADDR_W], dat_o[DATA_W] from the master; drives ack_i, stall_i, dat_i[DATA_W].
- clear_req  input  1: single-cycle pulse that starts a full-array clear.
- clear_done  output  1: single-cycle pulse on the last clear write.
- disp_addr  input  ADDR_W: display read address.
- disp_data  output  DATA_W: registered display read data.

Behaviour:
- Reset (rst=1 at posedge):
  - ack_i=0, dat_i=0, disp_data=0, clear_done=0.
  - Clear counter=0; state←CLEAR, so stall_i=1 from the first cycle after reset.
- States: CLEAR, READY.
- CLEAR:
  - Writes 0 to address cnt each cycle; cnt increments.
  - stall_i=1; no bus request is accepted.
  - At cnt==DEPTH-1: clear_done=1 for that cycle, cnt←0, state←READY.
  - DEPTH cycles total.
- READY:
  - stall_i=0.
  - clear_req=1 → state←CLEAR next cycle; stall_i=1 from that next cycle.
- Bus accept:
  - A request is accepted in a cycle where cyc_o & stb_o & !stall_i.
  - Pipelined: back-to-back accepts are allowed, one per cycle.
- Bus response:
  - ack_i=1 exactly one cycle after each accept, otherwise 0. No wait states.
  - Read: dat_i = mem[adr_o] registered with the ack.
  - Write: mem[adr_o]←dat_o at the accept edge; dat_i=0 with the ack.
- Out-of-range (adr_o ≥ DEPTH): still acked; write dropped; read returns 0.
- Read-after-write to the same address in consecutive accepts returns the new value; writes commit at the accept edge.
- clear_req coincident with an accepted request:
  - The request is accepted and acked normally the next cycle.
  - CLEAR begins the next cycle; the ack from the prior accept still issues while stall_i=1.
- clear_req while already in CLEAR: ignored; no restart, the counter continues.
- cyc_o dropped with a pending ack: the ack still issues; the master ignores it.
- Display port:
  - disp_data = mem[disp_addr] one cycle later, independent of the bus.
  - disp_addr ≥ DEPTH → 0.
  - During CLEAR, returns the current array contents; already-cleared cells read 0.
- Reset mid-clear or mid-transaction: aborts everything; ack_i=0; the clear restarts from 0.
- Memory is a simple dual-port-inferable array with one write port (bus or clear, muxed; clear has priority by construction since stall blocks the bus) and two read ports. No reset on the array contents themselves.

Decomposition:
- game_pkg gets:
  - cell bit-position constants (CELL_MINE_BIT=7, CELL_REVEALED_BIT=6, CELL_FLAG_BIT=5, CELL_CNT_MSB=3);
  - the DEPTH/ADDR_W defaults;
  - the state enum board_ram_state_t {CLEAR, READY}.
- Sub-module board_ram_core: the pure storage array (one write port, two synchronous read ports, no reset). game_board_ram wraps it with the Wishbone slave logic and the clear FSM.

Test Plan:
- Reset then idle → stall_i=1 for exactly 1024 cycles; clear_done pulses once on cycle 1024; then stall_i=0. Reading adr 0, 511 and 1023 returns 0x00.
- Write 0x85 to adr 37, then read adr 37 back to back → ack_i high on both following cycles; read dat_i=0x85; disp_addr=37 gives disp_data=0x85 one cycle later.
- Burst of 8 pipelined writes to adr 100..107 with data 0x10..0x17, stb held high → 8 consecutive ack_i cycles. Reads return the matching data.
- Write 0xFF to adr 1100 (≥DEPTH), then read adr 1100 → both acked; read dat_i=0x00; adr 1100 mod 1024 (=76) still holds its prior value.
- Write adr 5 = 0x40 with clear_req in the same cycle → ack next cycle; stall_i=1 for 1024 cycles; read adr 5 afterwards returns 0x00.
- Assert rst for 1 cycle at clear cycle 300 → ack_i=0; clear_done pulses 1024 cycles after rst falls, not earlier.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game board storage: cell bit layout, default sizes
// and the clear-sequencer state encoding.
package game_pkg;

    localparam int CELL_MINE_BIT     = 7;
    localparam int CELL_REVEALED_BIT = 6;
    localparam int CELL_FLAG_BIT     = 5;
    localparam int CELL_CNT_MSB      = 3;

    localparam int DEPTH_DEFAULT  = 1024;
    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } board_ram_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bundle; signal names follow the master's point of view
// (_o driven by the master, _i driven by the responder).
interface wishbone_if
    import game_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [ADDR_W-1:0] adr_o;
    logic [DATA_W-1:0] dat_o;
    logic              ack_i;
    logic              stall_i;
    logic [DATA_W-1:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  ack_i, stall_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output ack_i, stall_i, dat_i
    );
endinterface

// File: rtl/board_ram_core.sv
// Plain cell storage: one write port and two synchronous read ports, written so
// synthesis maps it onto a simple dual-port block RAM.
module board_ram_core #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_b_q;

    // NOTE: no reset here on purpose -- a reset on the array or its read
    // registers prevents block-RAM inference; the wrapper masks stale data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_a_q <= mem_q[raddr_a_i];
        rdata_b_q <= mem_q[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
endmodule

// File: rtl/game_board_ram.sv
// Wishbone responder around the board storage, with a clear sequencer that
// zeroes every cell after reset or on request while stalling the bus.
module game_board_ram
    import game_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    wishbone_if.slave         game_board_wb,
    input  logic              clear_req,
    output logic              clear_done,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data
);
    localparam int                CORE_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CORE_AW-1:0] LAST_CELL = CORE_AW'(DEPTH - 1);
    localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_LIM;
    endfunction

    board_ram_state_t     state_q, state_d;
    logic [CORE_AW-1:0]   cnt_q, cnt_d;
    logic                 ack_q;
    logic                 rd_valid_q;
    logic                 disp_valid_q;

    logic                 stall;
    logic                 accept;
    logic                 bus_in_range;
    logic                 mem_we;
    logic [CORE_AW-1:0]   mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    rdata_bus;
    logic [DATA_W-1:0]    rdata_disp;

    assign stall        = (state_q == CLEAR);
    assign accept       = game_board_wb.cyc_o & game_board_wb.stb_o & ~stall;
    assign bus_in_range = in_range(game_board_wb.adr_o);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_done = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = game_board_wb.adr_o[CORE_AW-1:0];
        mem_wdata  = game_board_wb.dat_o;
        unique case (state_q)
            CLEAR: begin
                mem_we    = ~rst;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_CELL) begin
                    clear_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = READY;
                end else begin
                    cnt_d = cnt_q + CORE_AW'(1);
                end
            end
            READY: begin
                // Out-of-range writes are acked but must never alias onto a real cell.
                mem_we = accept & game_board_wb.we_o & bus_in_range & ~rst;
                if (clear_req) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: every register below uses non-blocking assignment so all flops
    // sample their inputs from the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= accept;
            rd_valid_q   <= accept & ~game_board_wb.we_o & bus_in_range;
            disp_valid_q <= in_range(disp_addr);
        end
    end

    board_ram_core #(
        .DEPTH (DEPTH),
        .AW    (CORE_AW),
        .DW    (DATA_W)
    ) u_core (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (game_board_wb.adr_o[CORE_AW-1:0]),
        .rdata_a_o (rdata_bus),
        .raddr_b_i (disp_addr[CORE_AW-1:0]),
        .rdata_b_o (rdata_disp)
    );

    assign game_board_wb.ack_i   = ack_q;
    assign game_board_wb.stall_i = stall;
    assign game_board_wb.dat_i   = rd_valid_q ? rdata_bus : '0;
    assign disp_data             = disp_valid_q ? rdata_disp : '0;
endmodule

// File: tb/tb_game_board_ram.sv
// Directed bench for game_board_ram: bus vectors from a table plus hand-written
// clear, reset and display sequences. Inputs change and outputs are sampled on negedge.
module tb_game_board_ram;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdat;
        logic [DATA_W-1:0] exp_dat;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              clear_req;
    logic              clear_done;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    wishbone_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    game_board_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_board_wb (wb),
        .clear_req     (clear_req),
        .clear_done    (clear_done),
        .disp_addr     (disp_addr),
        .disp_data     (disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
        wb.cyc_o = 1'b1;
        wb.stb_o = 1'b1;
        wb.we_o  = we;
        wb.adr_o = adr;
        wb.dat_o = dat;
    endtask

    task automatic drive_idle();
        wb.cyc_o = 1'b0;
        wb.stb_o = 1'b0;
        wb.we_o  = 1'b0;
        wb.adr_o = '0;
        wb.dat_o = '0;
    endtask

    task automatic add_vec(input logic we, input int adr, input int wdat, input int exp_dat);
        vec_t v;
        v.we      = we;
        v.adr     = ADDR_W'(adr);
        v.wdat    = DATA_W'(wdat);
        v.exp_dat = DATA_W'(exp_dat);
        tbl.push_back(v);
    endtask

    // Called at the negedge of the first clear cycle; counts stall cycles until READY.
    // A clear_req pulse is injected at clear cycle pulse_at (0 = none) and must be ignored.
    task automatic run_clear(input string tag, input int pulse_at);
        int n;
        int done_cnt;
        int done_at;
        n = 0;
        done_cnt = 0;
        done_at = 0;
        for (int i = 0; i < 2000; i++) begin
            if (wb.stall_i !== 1'b1) break;
            n++;
            if (clear_done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
            clear_req = (n == pulse_at);
            @(negedge clk);
        end
        clear_req = 1'b0;
        check({tag, "_stall_cycles"}, n, DEPTH);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, DEPTH);
        check({tag, "_ready_stall"}, wb.stall_i, 1'b0);
    endtask

    initial begin
        int bad_done;
        int bad_stall;

        rst       = 1'b1;
        clear_req = 1'b0;
        disp_addr = '0;
        drive_idle();

        @(negedge clk);
        @(negedge clk);
        check("rst_ack", wb.ack_i, 1'b0);
        check("rst_dat", wb.dat_i, 8'h00);
        check("rst_disp", disp_data, 8'h00);
        check("rst_done", clear_done, 1'b0);
        check("rst_stall", wb.stall_i, 1'b1);
        rst = 1'b0;
        run_clear("init", 0);

        add_vec(1'b0, 0,    0,    8'h00);
        add_vec(1'b0, 511,  0,    8'h00);
        add_vec(1'b0, 1023, 0,    8'h00);
        add_vec(1'b1, 37,   8'h85, 8'h00);
        add_vec(1'b0, 37,   0,    8'h85);
        for (int k = 0; k < 8; k++) add_vec(1'b1, 100 + k, 8'h10 + k, 8'h00);
        for (int k = 0; k < 8; k++) add_vec(1'b0, 100 + k, 0, 8'h10 + k);
        add_vec(1'b1, 76,   8'h3C, 8'h00);
        add_vec(1'b1, 1100, 8'hFF, 8'h00);
        add_vec(1'b0, 1100, 0,    8'h00);
        add_vec(1'b0, 76,   0,    8'h3C);

        // Fully pipelined: one request per cycle, its ack is checked on the following cycle.
        for (int i = 0; i <= tbl.size(); i++) begin
            if (i > 0) begin
                check($sformatf("vec%0d_ack", i - 1), wb.ack_i, 1'b1);
                check($sformatf("vec%0d_dat_adr%0d", i - 1, tbl[i-1].adr), wb.dat_i, tbl[i-1].exp_dat);
            end
            if (i < tbl.size()) drive_req(tbl[i].we, tbl[i].adr, tbl[i].wdat);
            else drive_idle();
            @(negedge clk);
        end
        check("ack_after_burst", wb.ack_i, 1'b0);

        disp_addr = 11'd37;
        @(negedge clk);
        check("disp_37", disp_data, 8'h85);
        disp_addr = 11'd105;
        @(negedge clk);
        check("disp_105", disp_data, 8'h15);
        disp_addr = 11'd1100;
        @(negedge clk);
        check("disp_oor", disp_data, 8'h00);
        disp_addr = 11'd76;
        @(negedge clk);
        check("disp_76", disp_data, 8'h3C);

        // Clear interrupted by reset at clear cycle 300; display sees partial clearing.
        disp_addr = 11'd105;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        bad_done  = 0;
        bad_stall = 0;
        for (int k = 1; k <= 300; k++) begin
            if (clear_done !== 1'b0) bad_done++;
            if (wb.stall_i !== 1'b1) bad_stall++;
            if (k == 10) check("disp_uncleared", disp_data, 8'h15);
            if (k == 200) check("disp_cleared", disp_data, 8'h00);
            if (k < 300) @(negedge clk);
        end
        check("early_done", bad_done, 0);
        check("early_stall_drop", bad_stall, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midclr_rst_ack", wb.ack_i, 1'b0);
        check("midclr_rst_stall", wb.stall_i, 1'b1);
        check("midclr_rst_done", clear_done, 1'b0);
        rst = 1'b0;
        run_clear("midclr", 0);

        drive_req(1'b0, 11'd105, 8'h00);
        @(negedge clk);
        drive_idle();
        check("rd105_ack", wb.ack_i, 1'b1);
        check("rd105_dat", wb.dat_i, 8'h00);
        check("disp105_after", disp_data, 8'h00);

        // Reset coinciding with an accepted-looking request: no ack may follow.
        drive_req(1'b0, 11'd37, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("txn_rst_ack", wb.ack_i, 1'b0);
        check("txn_rst_stall", wb.stall_i, 1'b1);
        rst = 1'b0;
        drive_idle();
        run_clear("txnrst", 0);

        // Write with clear_req in the same cycle, then a redundant clear_req mid-clear.
        drive_req(1'b1, 11'd5, 8'h40);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        drive_idle();
        check("clrreq_ack", wb.ack_i, 1'b1);
        check("clrreq_dat", wb.dat_i, 8'h00);
        check("clrreq_stall", wb.stall_i, 1'b1);
        run_clear("clrreq", 500);

        drive_req(1'b0, 11'd5, 8'h00);
        @(negedge clk);
        drive_idle();
        check("rd5_ack", wb.ack_i, 1'b1);
        check("rd5_dat", wb.dat_i, 8'h00);
        @(negedge clk);
        check("rd5_ack_drop", wb.ack_i, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
